apb_master: RTL and testbench

- APB requester that converts a simple valid/ready command interface into APB3-style SETUP/ACCESS transfers.
- Waits on PREADY for any number of slave wait states, then returns read data or write completion on a one-cycle response strobe.
- Sits between the test/sequencer-side logic and the APB memory slave on the same PCLK domain.

---
 rtl/apb_master.sv | 151 +++++++++++++++
 tb/tb_apb_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB3 requester: valid/ready command in, SETUP/ACCESS transfer out, one-cycle response.
// Optional ACCESS timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic [15:0]       xfer_count,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] paddr_nxt;
   logic [DATA_W-1:0] pwdata_nxt;
   logic              pwrite_nxt;
   logic              psel_nxt;
   logic              penable_nxt;
   logic              rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;
   logic [15:0]       count_nxt;
   logic              abort;

   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_nxt     = state;
      paddr_nxt     = PADDR;
      pwdata_nxt    = PWDATA;
      pwrite_nxt    = PWRITE;
      psel_nxt      = 1'b0;
      penable_nxt   = 1'b0;
      rsp_valid_nxt = 1'b0;
      rsp_rdata_nxt = rsp_rdata;
      count_nxt     = xfer_count;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nxt  = SETUP;
               paddr_nxt  = cmd_addr;
               pwdata_nxt = cmd_wdata;
               pwrite_nxt = cmd_write;
               psel_nxt   = 1'b1;
            end
         end
         SETUP: begin
            state_nxt   = ACCESS;
            psel_nxt    = 1'b1;
            penable_nxt = 1'b1;
         end
         ACCESS: begin
            // PREADY is checked first so a late completion beats the abort
            if (PREADY) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
               count_nxt     = xfer_count + 16'd1;
            end else if (abort) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = '0;
               count_nxt     = xfer_count + 16'd1;
            end else begin
               psel_nxt    = 1'b1;
               penable_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state      <= IDLE;
         PADDR      <= '0;
         PWDATA     <= '0;
         PWRITE     <= 1'b0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         xfer_count <= '0;
      end else begin
         state      <= state_nxt;
         PADDR      <= paddr_nxt;
         PWDATA     <= pwdata_nxt;
         PWRITE     <= pwrite_nxt;
         PSEL       <= psel_nxt;
         PENABLE    <= penable_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_rdata  <= rsp_rdata_nxt;
         xfer_count <= count_nxt;
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] to_cnt;
   logic          err_q;

   assign abort = (state == ACCESS) && !PREADY &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         // held at zero in IDLE, so every SETUP starts a fresh count
         if (state == IDLE)
            to_cnt <= '0;
         else if (state == ACCESS && !PREADY)
            to_cnt <= to_cnt + TW'(1);
         if (state == ACCESS && (PREADY || abort))
            err_q <= !PREADY;
      end
   end

   assign rsp_error = err_q;
`else
   logic unused_timeout;

   assign abort          = 1'b0;
   assign rsp_error      = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small APB memory slave model.
// The slave can insert wait states or tie PREADY high or low.
module tb_apb_master;

   logic        PCLK;
   logic        PRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [15:0] xfer_count;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int lat;
   int k;
   int n;
   logic seen;

   // slave model: mode 0 = wait states, 1 = PREADY tied 1, 2 = tied 0
   int          mode;
   int          waits;
   int          wcnt;
   logic [31:0] mem [0:255];

   apb_master #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .PCLK(PCLK),
      .PRESET(PRESET),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error),
      .xfer_count(xfer_count),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PWRITE(PWRITE),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PRDATA(PRDATA),
      .PREADY(PREADY)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   always_comb begin
      case (mode)
         0:       PREADY = PSEL && PENABLE && (wcnt == waits);
         1:       PREADY = 1'b1;
         default: PREADY = 1'b0;
      endcase
   end

   assign PRDATA = (PSEL && !PWRITE) ? mem[PADDR[7:0]] : 'z;

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE)
         mem[PADDR[7:0]] <= PWDATA;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         fails = fails + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // starts and ends just after a negedge; lat = edges from accept to rsp
   task automatic do_cmd(input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lt);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      @(posedge PCLK);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      lt = 0;
      while (!rsp_valid && lt < 60) begin
         @(posedge PCLK);
         @(negedge PCLK);
         lt++;
      end
   endtask

   initial begin
      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      mode      = 0;
      waits     = 2;
      repeat (2) @(negedge PCLK);

      chk("rst_apb_ctl", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
      chk("rst_paddr", PADDR, 32'd0);
      chk("rst_pwdata", PWDATA, 32'd0);
      chk("rst_rsp", {30'd0, rsp_valid, rsp_error}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_count", {16'd0, xfer_count}, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      PRESET = 1'b0;
      @(negedge PCLK);

      // two wait states
      do_cmd(1'b1, 32'h10, 32'hA5A5_0001, lat);
      chk("w2_lat", lat, 32'd4);
      chk("w2_err", {31'd0, rsp_error}, 32'd0);
      chk("w2_rdata", rsp_rdata, 32'd0);
      do_cmd(1'b0, 32'h10, 32'h0, lat);
      chk("r2_lat", lat, 32'd4);
      chk("r2_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("r2_count", {16'd0, xfer_count}, 32'd2);

      // zero wait, PREADY tied high
      mode      = 1;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h10;
      @(posedge PCLK);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      cmd_addr  = 32'h55;
      chk("zw_setup", {30'd0, PSEL, PENABLE}, 32'd2);
      chk("zw_setup_addr", PADDR, 32'h10);
      chk("zw_setup_rdy", {31'd0, cmd_ready}, 32'd0);
      @(posedge PCLK);
      @(negedge PCLK);
      chk("zw_access", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd6);
      chk("zw_access_addr", PADDR, 32'h10);
      @(posedge PCLK);
      @(negedge PCLK);
      chk("zw_done", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd1);
      chk("zw_rdata", rsp_rdata, 32'hA5A5_0001);
      @(posedge PCLK);
      @(negedge PCLK);
      chk("zw_strobe_1cyc", {31'd0, rsp_valid}, 32'd0);
      chk("zw_rdata_hold", rsp_rdata, 32'hA5A5_0001);
      chk("zw_count", {16'd0, xfer_count}, 32'd3);

      // back-to-back writes with cmd_valid held high
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cmd_addr  = i;
         cmd_wdata = i + 1;
         @(posedge PCLK);
         @(negedge PCLK);
         k = 1;
         while (!cmd_ready && k < 10) begin
            @(posedge PCLK);
            @(negedge PCLK);
            k++;
         end
         if (i == 3) cmd_valid = 1'b0;
         chk($sformatf("b2b_period_%0d", i), k, 32'd3);
         chk($sformatf("b2b_rsp_%0d", i), {31'd0, rsp_valid}, 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         do_cmd(1'b0, i, 32'h0, lat);
         chk($sformatf("b2b_rd_%0d", i), rsp_rdata, i + 1);
      end
      chk("b2b_count", {16'd0, xfer_count}, 32'd11);

      // reset in the middle of ACCESS
      mode      = 0;
      waits     = 2;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h10;
      @(posedge PCLK);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      chk("mr_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
      PRESET = 1'b1;
      #1;
      chk("mr_drop", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("mr_count", {16'd0, xfer_count}, 32'd0);
      @(negedge PCLK);
      PRESET = 1'b0;
      seen   = 1'b0;
      repeat (6) begin
         @(posedge PCLK);
         @(negedge PCLK);
         if (rsp_valid || PSEL) seen = 1'b1;
      end
      chk("mr_no_rsp", {31'd0, seen}, 32'd0);
      do_cmd(1'b0, 32'h10, 32'h0, lat);
      chk("mr_next_lat", lat, 32'd4);
      chk("mr_next_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("mr_next_count", {16'd0, xfer_count}, 32'd1);

      // slave never ready
      mode      = 2;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h10;
      @(posedge PCLK);
      @(negedge PCLK);
      cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      n = 0;
      k = 0;
      while (!rsp_valid && k < 50) begin
         if (PENABLE) n++;
         @(posedge PCLK);
         @(negedge PCLK);
         k++;
      end
      chk("to_access_cycles", n, 32'd4);
      chk("to_rsp", {29'd0, rsp_valid, rsp_error, PSEL}, 32'd6);
      chk("to_rdata", rsp_rdata, 32'd0);
      chk("to_count", {16'd0, xfer_count}, 32'd2);
`else
      repeat (100) begin
         @(posedge PCLK);
         @(negedge PCLK);
      end
      chk("nto_stuck", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd6);
      chk("nto_err", {31'd0, rsp_error}, 32'd0);
      PRESET = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
      @(negedge PCLK);
`endif

      // counter wrap from a preloaded value
      mode = 1;
      force dut.xfer_count = 16'hFFFE;
      @(posedge PCLK);
      @(negedge PCLK);
      release dut.xfer_count;
      do_cmd(1'b1, 32'h30, 32'h7, lat);
      chk("wr_lat", lat, 32'd2);
      chk("wr_err_clr", {31'd0, rsp_error}, 32'd0);
      chk("wr_count_ffff", {16'd0, xfer_count}, 32'h0000_FFFF);
      do_cmd(1'b0, 32'h30, 32'h0, lat);
      chk("wr_rdata", rsp_rdata, 32'h7);
      chk("wr_count_0", {16'd0, xfer_count}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
